// File: rtl/int_rf_wb_arbiter_if.sv
// Writeback request channel into the register-file write arbiter.
// One instance per source (execute pipe, memory pipe).
interface int_rf_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output addr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    output ready
  );
endinterface

// File: rtl/int_rf_wb_arbiter.sv
// Integer RF write-port arbiter: per-source writeback FIFOs,
// mem-first priority with exe starvation guard, pending mask.
module int_rf_wb_fifo #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              nonempty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [31:0]       mask
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     wr_q;
  logic [PW-1:0]     rd_q;
  logic [CW-1:0]     cnt_q;

  assign full      = cnt_q == CW'(DEPTH);
  assign nonempty  = cnt_q != '0;
  assign head_addr = addr_q[rd_q];
  assign head_data = data_q[rd_q];

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      if (push) begin
        vld_q[wr_q] <= 1'b1;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= rd_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[wr_q] <= push_addr;
      data_q[wr_q] <= push_data;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i]) mask[addr_q[i]] = 1'b1;
  end
endmodule

module int_rf_wb_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 lock,
  int_rf_wb_arbiter_if.slave   exe,
  int_rf_wb_arbiter_if.slave   mem,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [31:0]          busy_mask
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic              exe_full, mem_full;
  logic              exe_ne, mem_ne;
  logic              exe_push, mem_push;
  logic              gnt_exe, gnt_mem;
  logic [ADDR_W-1:0] exe_haddr, mem_haddr;
  logic [DATA_W-1:0] exe_hdata, mem_hdata;
  logic [31:0]       exe_mask, mem_mask, out_mask;
  logic [SW-1:0]     starve_q;
  logic              starved;

  assign exe.ready = RSTN && !exe_full;
  assign mem.ready = RSTN && !mem_full;

  // x0 writes complete the handshake but are never stored
  assign exe_push = exe.valid && exe.ready && (exe.addr != '0);
  assign mem_push = mem.valid && mem.ready && (mem.addr != '0);

  int_rf_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_exe (
    .CLK(CLK), .RSTN(RSTN),
    .push(exe_push), .pop(gnt_exe),
    .push_addr(exe.addr), .push_data(exe.data),
    .full(exe_full), .nonempty(exe_ne),
    .head_addr(exe_haddr), .head_data(exe_hdata),
    .mask(exe_mask)
  );

  int_rf_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .CLK(CLK), .RSTN(RSTN),
    .push(mem_push), .pop(gnt_mem),
    .push_addr(mem.addr), .push_data(mem.data),
    .full(mem_full), .nonempty(mem_ne),
    .head_addr(mem_haddr), .head_data(mem_hdata),
    .mask(mem_mask)
  );

  assign starved = starve_q == SW'(STARVE_MAX);
  assign gnt_exe = !lock && exe_ne && (!mem_ne || starved);
  assign gnt_mem = !lock && mem_ne && !gnt_exe;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      starve_q <= '0;
    end else begin
      rf_we <= gnt_exe || gnt_mem;
      if (gnt_exe) begin
        rf_waddr <= exe_haddr;
        rf_wdata <= exe_hdata;
      end else if (gnt_mem) begin
        rf_waddr <= mem_haddr;
        rf_wdata <= mem_hdata;
      end
      if (!lock) begin
        if (exe_ne && !gnt_exe)
          starve_q <= starved ? starve_q : starve_q + SW'(1);
        else
          starve_q <= '0;
      end
    end
  end

  assign out_mask  = rf_we ? (32'd1 << rf_waddr) : '0;
  assign busy_mask = exe_mask | mem_mask | out_mask;
endmodule

// File: tb/tb_int_rf_wb_arbiter.sv
// Directed bench for int_rf_wb_arbiter.
// Hand-computed write order, masks and handshake levels.
module tb_int_rf_wb_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          lock;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   busy_mask;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] wlog[$];
  bit            logging = 1'b0;

  int_rf_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) exe_if ();
  int_rf_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

  int_rf_wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(2), .STARVE_MAX(4)
  ) dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .lock(lock),
    .exe(exe_if.slave),
    .mem(mem_if.slave),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .busy_mask(busy_mask)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input bit sel_mem,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d,
                      output bit ok);
    logic r;
    ok = 1'b0;
    if (sel_mem) begin
      mem_if.valid = 1'b1; mem_if.addr = a; mem_if.data = d;
    end else begin
      exe_if.valid = 1'b1; exe_if.addr = a; exe_if.data = d;
    end
    for (int i = 0; i < 50; i++) begin
      r = sel_mem ? mem_if.ready : exe_if.ready;
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (sel_mem) mem_if.valid = 1'b0;
    else         exe_if.valid = 1'b0;
  endtask

  always @(posedge CLK) begin
    #1;
    if (logging && rf_we === 1'b1) wlog.push_back(rf_waddr);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] exp_order [12];
    bit ok_m, ok_x;
    exp_order = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd5,
                  5'd6, 5'd7, 5'd8, 5'd10, 5'd11, 5'd12};

    RSTN = 1'b0;
    lock = 1'b0;
    exe_if.valid = 1'b1; exe_if.addr = 5'd3; exe_if.data = 64'h1;
    mem_if.valid = 1'b0; mem_if.addr = '0;   mem_if.data = '0;

    repeat (3) begin
      tick();
      check("rst_exe_ready", 64'(exe_if.ready), 64'd0);
      check("rst_we", 64'(rf_we), 64'd0);
      check("rst_mask", 64'(busy_mask), 64'd0);
    end
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    exe_if.valid = 1'b0;
    RSTN = 1'b1;
    #1;
    check("rel_exe_ready", 64'(exe_if.ready), 64'd1);

    // single exe write
    exe_if.valid = 1'b1; exe_if.addr = 5'd5; exe_if.data = 64'hDEAD_BEEF;
    tick();
    exe_if.valid = 1'b0;
    check("one_mask_e0", 64'(busy_mask), 64'h20);
    check("one_we_e0", 64'(rf_we), 64'd0);
    tick();
    check("one_we", 64'(rf_we), 64'd1);
    check("one_waddr", 64'(rf_waddr), 64'd5);
    check("one_wdata", rf_wdata, 64'hDEAD_BEEF);
    check("one_mask_e1", 64'(busy_mask), 64'h20);
    tick();
    check("one_we_off", 64'(rf_we), 64'd0);
    check("one_mask_off", 64'(busy_mask), 64'd0);

    // contention and starvation guard
    wlog.delete();
    logging = 1'b1;
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          send(1'b1, AW'(i), 64'h100 + 64'(i), ok_m);
          check("mem_accept", 64'(ok_m), 64'd1);
        end
      end
      begin
        for (int i = 9; i <= 12; i++) begin
          send(1'b0, AW'(i), 64'h200 + 64'(i), ok_x);
          check("exe_accept", 64'(ok_x), 64'd1);
        end
      end
    join
    repeat (4) tick();
    logging = 1'b0;
    check("starve_count", 64'(wlog.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < wlog.size())
        check($sformatf("starve_order%0d", i),
              64'(wlog[i]), 64'(exp_order[i]));
    end

    // lock and backpressure
    lock = 1'b1;
    exe_if.valid = 1'b1; exe_if.addr = 5'd20; exe_if.data = 64'h20;
    tick();
    check("bp_ready1", 64'(exe_if.ready), 64'd1);
    exe_if.addr = 5'd21; exe_if.data = 64'h21;
    tick();
    exe_if.addr = 5'd22; exe_if.data = 64'h22;
    check("bp_full", 64'(exe_if.ready), 64'd0);
    check("bp_mask", 64'(busy_mask), 64'h0030_0000);
    check("bp_we_lock", 64'(rf_we), 64'd0);
    tick();
    check("bp_still_full", 64'(exe_if.ready), 64'd0);
    check("bp_we_lock2", 64'(rf_we), 64'd0);
    lock = 1'b0;
    tick();
    check("bp_w0_we", 64'(rf_we), 64'd1);
    check("bp_w0_addr", 64'(rf_waddr), 64'd20);
    check("bp_ready_back", 64'(exe_if.ready), 64'd1);
    tick();
    exe_if.valid = 1'b0;
    check("bp_w1_addr", 64'(rf_waddr), 64'd21);
    tick();
    check("bp_w2_addr", 64'(rf_waddr), 64'd22);
    check("bp_w2_data", rf_wdata, 64'h22);
    tick();
    check("bp_idle", 64'(rf_we), 64'd0);

    // x0 destination is dropped
    mem_if.valid = 1'b1; mem_if.addr = 5'd0; mem_if.data = 64'hFF;
    check("x0_ready", 64'(mem_if.ready), 64'd1);
    tick();
    mem_if.valid = 1'b0;
    check("x0_mask", 64'(busy_mask), 64'd0);
    check("x0_we0", 64'(rf_we), 64'd0);
    tick();
    check("x0_we1", 64'(rf_we), 64'd0);
    check("x0_mask1", 64'(busy_mask), 64'd0);

    // reset with work in flight
    exe_if.valid = 1'b1; exe_if.addr = 5'd3; exe_if.data = 64'h33;
    tick();
    exe_if.addr = 5'd4; exe_if.data = 64'h44;
    mem_if.valid = 1'b1; mem_if.addr = 5'd8; mem_if.data = 64'h88;
    tick();
    exe_if.valid = 1'b0;
    mem_if.valid = 1'b0;
    check("mid_we", 64'(rf_we), 64'd1);
    check("mid_waddr", 64'(rf_waddr), 64'd3);
    check("mid_mask", 64'(busy_mask), 64'h118);
    RSTN = 1'b0;
    tick();
    check("mid_rst_we", 64'(rf_we), 64'd0);
    check("mid_rst_waddr", 64'(rf_waddr), 64'd0);
    check("mid_rst_mask", 64'(busy_mask), 64'd0);
    check("mid_rst_ready", 64'(exe_if.ready), 64'd0);
    RSTN = 1'b1;
    repeat (4) begin
      tick();
      check("post_rst_we", 64'(rf_we), 64'd0);
      check("post_rst_mask", 64'(busy_mask), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
